rnd_setup_scheduler: RTL and testbench
======================================

# rnd_setup_scheduler

Shares one free-running 32-bit LFSR between up to N_REQ setup generators, for example the serial-number generator and the wire/module randomisers. Each generator is a requester, and requests are served one per cycle in round-robin order. The block also sequences the ACTIVATING phase of the bomb: it tracks each generator's completion and reports a single `setup_done` (or `setup_err` on timeout) to the main game FSM.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, legal range 2..8.
- `SEED`, default 32'hACE1_2468: LFSR reset value; must be nonzero.
- `TIMEOUT`, default 16'd1024: watchdog limit in cycles spent in RUN.

Ports (clock and reset first):
- `clk`  input  1  system clock.
- `rst`  input  1  reset, asynchronous, active-low.
- `current_state`  input  3  game FSM state; ACTIVATING = 3'b001.
- `req`  input  N_REQ  per-requester "need a random word" request, level-sensitive.
- `done_in`  input  N_REQ  per-requester completion pulse or level.
- `gnt`  output  N_REQ  one-hot grant, registered.
- `rnd`  output  32  LFSR word, registered; valid for the requester whose `gnt` bit is high.
- `rnd_valid`  output  1  equals |gnt.
- `setup_done`  output  1  all requesters have finished; sticky until the block leaves DONE.
- `setup_err`  output  1  watchdog expired; sticky until the block leaves FAIL.

## Operation
- **LFSR:** Galois, right-shift, mask 32'h8020_0003. Each cycle, if lsb=1 the next value is (x>>1)^mask, otherwise x>>1. It steps every cycle after reset regardless of state. `rnd` always shows the current LFSR value, so every grant sees a distinct word.
- **Sequencer states:** IDLE, RUN, DONE, FAIL.
  - IDLE -> RUN when `current_state`==ACTIVATING. On entry: clear `fin_mask`, clear the watchdog count, and set the round-robin pointer to 0.
  - RUN -> DONE when `fin_mask | done_in` is all ones.
  - RUN -> FAIL when the watchdog count reaches TIMEOUT-1 and RUN -> DONE is not also true that cycle. DONE has priority.
  - Any state -> IDLE whenever `current_state`!=ACTIVATING. This is the abort path: `fin_mask`, `gnt`, `setup_done` and `setup_err` all clear on the next edge.
  - DONE and FAIL hold while ACTIVATING persists.
- **fin_mask:** an N_REQ-bit register. A bit is set when the corresponding `done_in` bit is high in RUN. Finished requesters are masked out of arbitration.
- **Arbiter (RUN only):**
  - Eligible requesters are `req & ~fin_mask & ~done_in`.
  - Search starts at the pointer, lowest index first, with wrap-around.
  - The winner's `gnt` bit is high for exactly one cycle. The pointer then moves to winner+1, wrapping modulo N_REQ.
  - With no eligible requester, `gnt` is 0 and the pointer holds.
  - A requester that holds `req` high gets one grant per round. It must drop `req` in the cycle it sees `gnt`, or it will be served again on its next turn.
- **Outside RUN:** `gnt`=0, `rnd_valid`=0. `rnd` keeps stepping.

## Timing
- Reset values: `gnt`=0, `rnd_valid`=0, `rnd`=SEED, `setup_done`=0, `setup_err`=0, state IDLE, pointer 0, `fin_mask`=0.
- Entry: `current_state` becomes ACTIVATING at edge t, so the state is RUN after edge t+1.
- Grant latency: a `req` sampled at edge k produces `gnt` high in cycle k+1 if that requester wins. `rnd` in that same cycle is the word it consumes.
- With all N requesters requesting, the worst-case wait is N_REQ cycles.
- `setup_done` rises one cycle after the edge that completes the mask.
- Watchdog: it counts RUN cycles starting from 0. `setup_err` rises after TIMEOUT cycles spent in RUN.
- A `done_in` and a `gnt` for the same requester in the same cycle are legal. The grant is still issued and the bit is masked from the next cycle on.

## Configuration
- Macro `RND_SETUP_TIMEOUT_EN`.
- Defined: the watchdog counter and the FAIL state are built, and `setup_err` behaves as described above.
- Undefined: no counter and no FAIL state; `setup_err` is tied to 0, and RUN leaves only via DONE or abort. `TIMEOUT` is ignored.

## Test plan
1. Release reset and hold `current_state`=IDLE -> `rnd`=32'hACE1_2468 in the first cycle, then 32'h5670_9234, and `gnt` stays 0.
2. ACTIVATING with `req`=4'b1111 held -> `gnt` sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, and each grant's `rnd` differs from the previous one.
3. `req`=4'b1010 and the pointer at 0 -> `gnt`=0010 then 1000. Next, `done_in[1]` pulses -> subsequent grants go only to bit 3.
4. Requesters 0..3 pulse `done_in` at cycles 5, 9, 9 and 20 of RUN -> `setup_done`=1 one cycle after cycle 20. It stays high until `current_state` leaves ACTIVATING, then clears.
5. With `RND_SETUP_TIMEOUT_EN` and TIMEOUT=16, `done_in` never asserted -> `setup_err`=1 after 16 RUN cycles and `gnt`=0 from then on. Without the macro -> `setup_err` stays 0 indefinitely.
6. Abort mid-RUN: `current_state` goes to DETONATING with 2 of 4 done -> the next cycle shows IDLE with `fin_mask`=0 and `gnt`=0. Re-entering ACTIVATING requires all four `done_in` again.

Source files
------------

// File: rtl/rnd_setup_scheduler.sv
// rnd_setup_scheduler: round-robin sharing of one Galois LFSR between N_REQ setup generators,
// plus the ACTIVATING-phase sequencer. Optional watchdog/FAIL state: RND_SETUP_TIMEOUT_EN.
module rnd_setup_scheduler #(
    parameter int          N_REQ   = 4,
    parameter logic [31:0] SEED    = 32'hACE1_2468,
    parameter logic [15:0] TIMEOUT = 16'd1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       current_state,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done_in,
    output logic [N_REQ-1:0] gnt,
    output logic [31:0]      rnd,
    output logic             rnd_valid,
    output logic             setup_done,
    output logic             setup_err,
    output logic [1:0]       dbg_state
);
    localparam logic [2:0]    ACTIVATING = 3'b001;
    localparam logic [31:0]   LFSR_MASK  = 32'h8020_0003;
    localparam int            PW         = $clog2(N_REQ);
    localparam logic [PW-1:0] LAST       = PW'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    state_t           state, next_state;
    logic [N_REQ-1:0] fin_mask, eligible, win_onehot;
    logic [PW-1:0]    ptr, win_idx;
    logic [PW:0]      cand;
    logic             found, activating, all_done, wd_expired;

    if (N_REQ < 2 || N_REQ > 8 || SEED == 32'd0 || TIMEOUT == 16'd0) begin : g_bad_params
        $error("rnd_setup_scheduler: illegal parameter set");
    end

    // The LFSR free-runs in every state so each grant consumes a distinct word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        rnd <= SEED;
        else if (rnd[0]) rnd <= (rnd >> 1) ^ LFSR_MASK;
        else             rnd <= rnd >> 1;
    end

    assign activating = (current_state == ACTIVATING);
    assign all_done   = &(fin_mask | done_in);
    assign eligible   = req & ~fin_mask & ~done_in;

`ifdef RND_SETUP_TIMEOUT_EN
    logic [15:0] wd_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               wd_cnt <= '0;
        else if (state != S_RUN) wd_cnt <= '0;
        else                    wd_cnt <= wd_cnt + 16'd1;
    end

    assign wd_expired = (wd_cnt == TIMEOUT - 16'd1);
`else
    assign wd_expired = 1'b0;
`endif

    // Rotating search: first eligible index at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr} + (PW+1)'(i);
            if (cand >= (PW+1)'(N_REQ)) cand = cand - (PW+1)'(N_REQ);
            if (!found && eligible[cand[PW-1:0]]) begin
                found   = 1'b1;
                win_idx = cand[PW-1:0];
            end
        end
    end

    assign win_onehot = found ? ({{(N_REQ-1){1'b0}}, 1'b1} << win_idx) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (!activating) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE: next_state = S_RUN;
                S_RUN: begin
                    if (all_done)        next_state = S_DONE;
                    else if (wd_expired) next_state = S_FAIL;
                end
                default: next_state = state;
            endcase
        end
    end

    // Grants are only issued into a cycle that is still RUN; abort clears everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fin_mask <= '0;
            ptr      <= '0;
            gnt      <= '0;
        end else if (state == S_IDLE || next_state == S_IDLE) begin
            fin_mask <= '0;
            ptr      <= '0;
            gnt      <= '0;
        end else begin
            if (state == S_RUN) fin_mask <= fin_mask | done_in;
            if (state == S_RUN && next_state == S_RUN && found) begin
                gnt <= win_onehot;
                ptr <= (win_idx == LAST) ? '0 : win_idx + 1'b1;
            end else begin
                gnt <= '0;
            end
        end
    end

    always_comb begin
        rnd_valid  = |gnt;
        setup_done = (state == S_DONE);
`ifdef RND_SETUP_TIMEOUT_EN
        setup_err  = (state == S_FAIL);
`else
        setup_err  = 1'b0;
`endif
        dbg_state  = state;
    end

endmodule

// File: tb/tb_rnd_setup_scheduler.sv
// Bench for rnd_setup_scheduler: vector table plus hand sequences, queue-based scoreboard
// and an independent LFSR reference model.
module tb_rnd_setup_scheduler;
    localparam int          N       = 4;
    localparam logic [31:0] SEED    = 32'hACE1_2468;
    localparam logic [31:0] MASK    = 32'h8020_0003;
    localparam logic [2:0]  GS_IDLE = 3'b000;
    localparam logic [2:0]  GS_ACT  = 3'b001;
    localparam logic [2:0]  GS_DET  = 3'b100;
    localparam logic [1:0]  ST_IDLE = 2'd0;
    localparam logic [1:0]  ST_RUN  = 2'd1;
`ifdef RND_SETUP_TIMEOUT_EN
    localparam bit timeout_on = 1'b1;
    localparam int LAST_DONE  = 16;
`else
    localparam bit timeout_on = 1'b0;
    localparam int LAST_DONE  = 20;
`endif

    typedef struct packed {
        logic [2:0]   cs;
        logic [N-1:0] req;
        logic [N-1:0] done;
        logic [N-1:0] gnt;
    } vec_t;

    logic         clk, rst;
    logic [2:0]   current_state;
    logic [N-1:0] req, done_in, gnt;
    logic [31:0]  rnd, m_lfsr, prev_rnd;
    logic         rnd_valid, setup_done, setup_err;
    logic [1:0]   dbg_state;
    logic [5:0]   exp_q[$];
    vec_t         tbl[16];
    int           total, bad;
    logic [N-1:0] d_pat, g_exp;
    bit           have_prev;

    rnd_setup_scheduler #(
        .N_REQ(N),
        .SEED(SEED),
        .TIMEOUT(16'd16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .current_state(current_state),
        .req(req),
        .done_in(done_in),
        .gnt(gnt),
        .rnd(rnd),
        .rnd_valid(rnd_valid),
        .setup_done(setup_done),
        .setup_err(setup_err),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ MASK) : (x >> 1);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= SEED;
        else      m_lfsr <= lfsr_step(m_lfsr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // driver: inputs for the next edge, expected {err, done, gnt} for the cycle after it
    task automatic drive(input logic [2:0] cs, input logic [N-1:0] r, input logic [N-1:0] d,
                         input logic [5:0] e);
        current_state = cs;
        req           = r;
        done_in       = d;
        exp_q.push_back(e);
    endtask

    // scoreboard: advance one cycle, pop and compare
    task automatic step(input string name);
        logic [5:0] e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            check({name, "_gnt"}, 32'(gnt), 32'(e[3:0]));
            check({name, "_valid"}, 32'(rnd_valid), 32'(|e[3:0]));
            check({name, "_done"}, 32'(setup_done), 32'(e[4]));
            check({name, "_err"}, 32'(setup_err), 32'(e[5]));
            check({name, "_rnd"}, rnd, m_lfsr);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        have_prev = 1'b0;
        prev_rnd = '0;
        rst = 1'b0;
        current_state = GS_IDLE;
        req = '0;
        done_in = '0;

        // round robin with all requesting, abort, then sparse requests with a done pulse
        tbl[0]  = '{GS_ACT,  4'b1111, 4'b0000, 4'b0000};
        tbl[1]  = '{GS_ACT,  4'b1111, 4'b0000, 4'b0001};
        tbl[2]  = '{GS_ACT,  4'b1111, 4'b0000, 4'b0010};
        tbl[3]  = '{GS_ACT,  4'b1111, 4'b0000, 4'b0100};
        tbl[4]  = '{GS_ACT,  4'b1111, 4'b0000, 4'b1000};
        tbl[5]  = '{GS_ACT,  4'b1111, 4'b0000, 4'b0001};
        tbl[6]  = '{GS_IDLE, 4'b0000, 4'b0000, 4'b0000};
        tbl[7]  = '{GS_IDLE, 4'b0000, 4'b0000, 4'b0000};
        tbl[8]  = '{GS_ACT,  4'b1010, 4'b0000, 4'b0000};
        tbl[9]  = '{GS_ACT,  4'b1010, 4'b0000, 4'b0010};
        tbl[10] = '{GS_ACT,  4'b1010, 4'b0000, 4'b1000};
        tbl[11] = '{GS_ACT,  4'b1010, 4'b0000, 4'b0010};
        tbl[12] = '{GS_ACT,  4'b1010, 4'b0010, 4'b1000};
        tbl[13] = '{GS_ACT,  4'b1010, 4'b0000, 4'b1000};
        tbl[14] = '{GS_ACT,  4'b1010, 4'b0000, 4'b1000};
        tbl[15] = '{GS_IDLE, 4'b0000, 4'b0000, 4'b0000};

        // reset state and first LFSR words
        repeat (3) @(negedge clk);
        check("rst_rnd", rnd, SEED);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_valid", 32'(rnd_valid), 32'd0);
        check("rst_done", 32'(setup_done), 32'd0);
        check("rst_err", 32'(setup_err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b1;
        @(negedge clk);
        check("lfsr_word1", rnd, 32'h5670_9234);
        drive(GS_IDLE, '0, '0, 6'b0);
        step("idle_a");
        drive(GS_IDLE, 4'b1111, '0, 6'b0);
        step("idle_req");

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].cs, tbl[i].req, tbl[i].done, {2'b00, tbl[i].gnt});
            step($sformatf("vec%0d", i));
            if (i < 6 && tbl[i].gnt != '0) begin
                if (have_prev) begin
                    total++;
                    if (rnd == prev_rnd) begin
                        bad++;
                        $display("FAIL vec%0d_rnd_repeat got=%h exp=!%h", i, rnd, prev_rnd);
                    end
                end
                prev_rnd = rnd;
                have_prev = 1'b1;
            end
        end
        check("abort_state", 32'(dbg_state), 32'(ST_IDLE));

        // staggered completion; in the watchdog build the last done lands on the timeout cycle
        drive(GS_ACT, '0, '0, 6'b0);
        step("t4_entry");
        check("t4_state", 32'(dbg_state), 32'(ST_RUN));
        for (int c = 1; c <= LAST_DONE; c++) begin
            d_pat = '0;
            if (c == 5) d_pat[0] = 1'b1;
            if (c == 9) d_pat[2:1] = 2'b11;
            if (c == LAST_DONE) d_pat[3] = 1'b1;
            drive(GS_ACT, '0, d_pat, {1'b0, (c == LAST_DONE), 4'b0000});
            step($sformatf("t4_c%0d", c));
        end
        repeat (3) begin
            drive(GS_ACT, 4'b1111, '0, 6'b01_0000);
            step("t4_hold");
        end
        drive(GS_IDLE, '0, '0, 6'b0);
        step("t4_leave");

        // watchdog: no done_in at all, requests held
        drive(GS_ACT, 4'b1111, '0, 6'b0);
        step("t5_entry");
        for (int c = 1; c <= 24; c++) begin
            if (timeout_on && c >= 16) g_exp = '0;
            else                       g_exp = 4'(4'b0001 << ((c - 1) % 4));
            drive(GS_ACT, 4'b1111, '0, {(timeout_on && c >= 16), 1'b0, g_exp});
            step($sformatf("t5_c%0d", c));
        end
        drive(GS_IDLE, '0, '0, 6'b0);
        step("t5_leave");

        // abort with two of four done; re-entry must need all four again
        drive(GS_ACT, '0, '0, 6'b0);
        step("t6_entry");
        drive(GS_ACT, '0, 4'b0011, 6'b0);
        step("t6_half");
        drive(GS_ACT, '0, '0, 6'b0);
        step("t6_wait");
        drive(GS_DET, 4'b1111, '0, 6'b0);
        step("t6_abort");
        check("t6_abort_state", 32'(dbg_state), 32'(ST_IDLE));
        drive(GS_ACT, '0, '0, 6'b0);
        step("t6_reentry");
        drive(GS_ACT, '0, 4'b1100, 6'b0);
        step("t6_upper");
        drive(GS_ACT, '0, '0, 6'b0);
        step("t6_not_done_a");
        drive(GS_ACT, '0, '0, 6'b0);
        step("t6_not_done_b");
        drive(GS_ACT, '0, 4'b0011, 6'b01_0000);
        step("t6_done");
        drive(GS_ACT, '0, '0, 6'b01_0000);
        step("t6_sticky");
        drive(GS_IDLE, '0, '0, 6'b0);
        step("t6_leave");

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
